// File: rtl/divider32_seq.sv
`default_nettype none
// ============================================================================
// Module      : divider32_seq
// Description : Multicycle integer divider using restoring shift-subtract.
//               It produces one quotient bit per cycle and supports signed and
//               unsigned operands. Quotient truncates toward zero, and the
//               remainder takes the sign of the dividend. A start/busy/done
//               handshake allows the pipeline to stall on the divider.
//               Fixed latency: 33 cycles from the accepted start edge to done.
// Ports       : clk          rising-edge clock
//               rst_n        asynchronous active-low reset
//               i_start      request, sampled only while idle
//               i_sign_mode  1 = two's-complement signed, 0 = unsigned
//               i_dividend   dividend, latched at start
//               i_divisor    divisor, latched at start
//               o_quotient   registered quotient
//               o_remainder  registered remainder
//               o_busy       high from accepted start until result load
//               o_done       one-cycle pulse when results become valid
//               o_dbz        divide-by-zero flag, held with results
// Revision    : 1.0 - initial release
// ============================================================================
module divider32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_sign_mode,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_dbz
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;    // partial remainder
    logic [WIDTH-1:0] r_dvd;    // dividend magnitude, becomes quotient magnitude
    logic [WIDTH-1:0] r_dvs;    // divisor magnitude
    logic [CNT_W-1:0] r_cnt;
    logic             r_qneg;
    logic             r_rneg;
    logic             r_zero;

    // Operand conditioning at start
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dvs_abs;

    assign w_dvd_neg = i_sign_mode & i_dividend[WIDTH-1];
    assign w_dvs_neg = i_sign_mode & i_divisor[WIDTH-1];
    assign w_dvd_abs = w_dvd_neg ? (~i_dividend + 1'b1) : i_dividend;
    assign w_dvs_abs = w_dvs_neg ? (~i_divisor + 1'b1) : i_divisor;

    // One restoring iteration. The shifted remainder is always below twice the
    // divisor, so bit WIDTH of the 33-bit difference acts as a sign/borrow bit.
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_rem_next;

    assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_dvs};
    assign w_q_bit    = ~w_diff[WIDTH];
    assign w_rem_next = w_q_bit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

    // Final sign correction. Negation wraps in WIDTH bits, so the magnitude
    // 0x80000000 stays 0x80000000. A zero divisor forces an all-ones
    // quotient. The remainder is then the dividend magnitude with the
    // dividend's sign restored, which gives back the original dividend.
    logic [WIDTH-1:0] w_quot_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_quot_fix = r_zero ? {WIDTH{1'b1}}
                               : (r_qneg ? (~r_dvd + 1'b1) : r_dvd);
    assign w_rem_fix  = r_rneg ? (~r_rem + 1'b1) : r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_cnt       <= '0;
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
            r_zero      <= 1'b0;
            o_quotient  <= '0;
            o_remainder <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_dbz       <= 1'b0;
        end else begin
            o_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_dvd   <= w_dvd_abs;
                        r_dvs   <= w_dvs_abs;
                        r_qneg  <= w_dvd_neg ^ w_dvs_neg;
                        r_rneg  <= w_dvd_neg;
                        r_zero  <= (i_divisor == '0);
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        o_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_rem <= w_rem_next;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_q_bit};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    o_quotient  <= w_quot_fix;
                    o_remainder <= w_rem_fix;
                    o_dbz       <= r_zero;
                    o_done      <= 1'b1;
                    o_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_divider32_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider32_seq
// Description : Self-checking bench for divider32_seq. An arithmetic reference
//               model predicts busy/done/results every cycle. Directed
//               vectors carry hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divider32_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic        i_sign_mode;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;
    logic        o_busy;
    logic        o_done;
    logic        o_dbz;

    int n_pass  = 0;
    int n_total = 0;

    divider32_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_sign_mode (i_sign_mode),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_dbz       (o_dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Reference division from the arithmetic rules: {dbz, quotient, remainder}
    function automatic logic [64:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                            input logic s);
        logic [31:0] q;
        logic [31:0] r;
        int sx;
        int sy;
        if (y == 32'd0) return {1'b1, 32'hFFFF_FFFF, x};
        if (!s) begin
            q = x / y;
            r = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            sx = $signed(x);
            sy = $signed(y);
            q  = 32'(sx / sy);
            r  = 32'(sx % sy);
        end
        return {1'b0, q, r};
    endfunction

    // Cycle-level expectation: an accepted operation completes 33 edges later;
    // a start arriving while an operation is outstanding is dropped.
    logic        m_pend;
    int          m_age;
    logic        m_done;
    logic [31:0] m_q;
    logic [31:0] m_r;
    logic        m_z;
    logic [64:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 1'b0;
            m_age  <= 0;
            m_done <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
            m_z    <= 1'b0;
            m_res  <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_pend) begin
                if (m_age == 32) begin
                    m_pend <= 1'b0;
                    m_done <= 1'b1;
                    m_z    <= m_res[64];
                    m_q    <= m_res[63:32];
                    m_r    <= m_res[31:0];
                end else begin
                    m_age <= m_age + 1;
                end
            end else if (i_start) begin
                m_pend <= 1'b1;
                m_age  <= 0;
                m_res  <= ref_div(i_dividend, i_divisor, i_sign_mode);
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy", 64'(o_busy), 64'(m_pend));
        chk("cyc_done", 64'(o_done), 64'(m_done));
        chk("cyc_quotient", 64'(o_quotient), 64'(m_q));
        chk("cyc_remainder", 64'(o_remainder), 64'(m_r));
        chk("cyc_dbz", 64'(o_dbz), 64'(m_z));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string nm, input logic [31:0] x, input logic [31:0] y,
                          input logic s, input logic [31:0] eq, input logic [31:0] er,
                          input logic ez);
        int k;
        i_dividend  = x;
        i_divisor   = y;
        i_sign_mode = s;
        i_start     = 1'b1;
        tick();
        // Scramble operands after acceptance; they must not matter.
        i_start     = 1'b0;
        i_dividend  = $urandom;
        i_divisor   = $urandom;
        i_sign_mode = 1'($urandom_range(0, 1));
        k = 0;
        while (!o_done && k < 60) begin
            tick();
            k++;
        end
        chk({nm, "_latency"}, 64'(k), 64'd33);
        chk({nm, "_quotient"}, 64'(o_quotient), 64'(eq));
        chk({nm, "_remainder"}, 64'(o_remainder), 64'(er));
        chk({nm, "_dbz"}, 64'(o_dbz), 64'(ez));
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  k;
        logic seen;
        rst_n       = 1'b1;
        i_start     = 1'b0;
        i_sign_mode = 1'b0;
        i_dividend  = '0;
        i_divisor   = '0;
        #2 rst_n = 1'b0;
        tick();
        chk("rst_quotient", 64'(o_quotient), 64'd0);
        chk("rst_remainder", 64'(o_remainder), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_dbz", 64'(o_dbz), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        run_op("u100_7",    32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0);
        run_op("s_m7_2",    32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
        run_op("s_7_m2",    32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0);
        run_op("u_ff_1",    32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0);
        run_op("s_m1_1",    32'hFFFF_FFFF,  32'd1,          1'b1, 32'hFFFF_FFFF,  32'd0,          1'b0);
        run_op("u_dbz",     32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1);
        run_op("s_dbz",     32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd5,          1'b1);
        run_op("u9_4_clr",  32'd9,          32'd4,          1'b0, 32'd2,          32'd1,          1'b0);
        run_op("s_ovf",     32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0);
        run_op("s_dbz_neg", 32'hFFFF_FFF8,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF8,  1'b1);
        run_op("s_dbz_min", 32'h8000_0000,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h8000_0000,  1'b1);
        run_op("s_m100_m7", 32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE,  1'b0);
        run_op("u_min_ff",  32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0);

        // start while busy must be ignored
        i_dividend = 32'd1000; i_divisor = 32'd3; i_sign_mode = 1'b0; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (9) tick();
        i_dividend = 32'd9; i_divisor = 32'd4; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        k = 10;
        while (!o_done && k < 60) begin
            tick();
            k++;
        end
        chk("busy_ign_latency", 64'(k), 64'd33);
        chk("busy_ign_quotient", 64'(o_quotient), 64'd333);
        chk("busy_ign_remainder", 64'(o_remainder), 64'd1);
        tick();

        // start held high: back-to-back operations every 34 cycles
        i_dividend = 32'd12; i_divisor = 32'd5; i_sign_mode = 1'b0; i_start = 1'b1;
        tick();
        k = 0;
        while (!o_done && k < 60) begin
            tick();
            k++;
        end
        chk("held_first_latency", 64'(k), 64'd33);
        tick();
        k = 1;
        while (!o_done && k < 80) begin
            tick();
            k++;
        end
        i_start = 1'b0;
        chk("held_period", 64'(k), 64'd34);
        chk("held_quotient", 64'(o_quotient), 64'd2);
        chk("held_remainder", 64'(o_remainder), 64'd2);
        tick();

        // reset in the middle of an operation
        i_dividend = 32'd1000; i_divisor = 32'd7; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(o_busy), 64'd0);
        chk("abort_quotient", 64'(o_quotient), 64'd0);
        chk("abort_remainder", 64'(o_remainder), 64'd0);
        chk("abort_dbz", 64'(o_dbz), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            tick();
            if (o_done) seen = 1'b1;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        run_op("after_rst", 32'd50, 32'd6, 1'b0, 32'd8, 32'd2, 1'b0);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
